// File: rtl/fp_pkg.sv
// Shared floating-point definitions: IEEE-754 single-precision constants,
// packed float layout and the fp_div controller state encoding.
package fp_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_DIVIDE,
    S_NORMALIZE,
    S_ROUND
  } fp_div_state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_div_iter.sv
// One restoring-division step: compares the partial remainder with the
// divisor mantissa, conditionally subtracts, and shifts left for the next bit.
module fp_div_iter (
  input  logic [24:0] rem,
  input  logic [23:0] mb,
  output logic [24:0] rem_next,
  output logic        q_bit
);

  logic [24:0] diff;
  logic [24:0] sel;

  assign q_bit    = (rem >= {1'b0, mb});
  assign diff     = rem - {1'b0, mb};
  assign sel      = q_bit ? diff : rem;
  // The kept remainder is always below mb, so the shift never loses a set bit.
  assign rem_next = sel << 1;

endmodule

// File: rtl/fp_div.sv
// Sequential single-precision divider: restoring mantissa divide, normalize,
// round-to-nearest-even. Define FP_DIV_SPECIAL_EN to decode exp-255 (inf/NaN).
module fp_div
  import fp_pkg::*;
#(
  parameter int QBITS = 27
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operando_a,
  input  logic [31:0] operando_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] resultado,
  output logic        div_zero
);

  fp_div_state_e state, state_next;

  fp32_t              fa, fb;
  logic               sign_in;
  logic signed [9:0]  exp_start;
  logic               is_special;
  logic [31:0]        spec_res;
  logic               spec_dz;

  logic [4:0]         cnt;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [24:0]        rem_r;
  logic [23:0]        mb_r;
  logic [QBITS-1:0]   q_r;
  logic [31:0]        spec_res_r;
  logic               spec_dz_r;

  logic [22:0]        frac_p1;
  logic               g_p1, r_p1, s_p1;

  logic [24:0]        rem_next;
  logic               q_bit;

  function automatic logic [31:0] round_pack(
    input logic              sign,
    input logic signed [9:0] e,
    input logic [22:0]       frac,
    input logic              g,
    input logic              r,
    input logic              s
  );
    logic [23:0]       sum;
    logic signed [9:0] ef;
    sum = {1'b0, frac} + {23'b0, g & (r | s | frac[0])};
    // A carry out of the fraction leaves sum[22:0] at zero: mantissa becomes 1.0.
    ef  = sum[23] ? e + 10'sd1 : e;
    if (ef >= signed'(10'(EXP_MAX)))
      round_pack = {sign, 8'hFF, 23'b0};
    else if (ef <= 10'sd0)
      round_pack = {sign, 31'b0};
    else
      round_pack = {sign, ef[7:0], sum[22:0]};
  endfunction

  assign fa        = operando_a;
  assign fb        = operando_b;
  assign sign_in   = fa.sign ^ fb.sign;
  assign exp_start = signed'({2'b00, fa.exp}) - signed'({2'b00, fb.exp})
                   + signed'(10'(EXP_BIAS));
  assign busy      = (state != S_IDLE);

  always_comb begin
    is_special = (fa.exp == 8'd0) || (fb.exp == 8'd0);
    spec_res   = {sign_in, 31'b0};
    spec_dz    = 1'b0;
    if (fb.exp == 8'd0 && fa.exp != 8'd0) begin
      spec_res = {sign_in, 8'hFF, 23'b0};
      spec_dz  = 1'b1;
    end
`ifdef FP_DIV_SPECIAL_EN
    if (fa.exp == 8'hFF || fb.exp == 8'hFF) begin
      is_special = 1'b1;
      spec_dz    = 1'b0;
      if ((fa.exp == 8'hFF && fa.frac != 23'd0) ||
          (fb.exp == 8'hFF && fb.frac != 23'd0) ||
          (fa.exp == 8'hFF && fb.exp == 8'hFF))
        spec_res = QNAN;
      else if (fa.exp == 8'hFF)
        spec_res = {sign_in, 8'hFF, 23'b0};
      else
        spec_res = {sign_in, 31'b0};
    end
`endif
  end

  fp_div_iter u_iter (
    .rem      (rem_r),
    .mb       (mb_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = is_special ? S_SPECIAL : S_DIVIDE;
      S_DIVIDE:    if (cnt == 5'd0) state_next = S_NORMALIZE;
      S_NORMALIZE: state_next = S_ROUND;
      S_ROUND:     state_next = S_IDLE;
      S_SPECIAL:   state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Stage p0: operand capture and one quotient bit per DIVIDE cycle
  always_ff @(posedge clock) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          sign_r     <= sign_in;
          exp_r      <= exp_start;
          rem_r      <= {1'b0, 1'b1, fa.frac};
          mb_r       <= {1'b1, fb.frac};
          q_r        <= '0;
          cnt        <= 5'(QBITS - 1);
          spec_res_r <= spec_res;
          spec_dz_r  <= spec_dz;
        end
      end
      S_DIVIDE: begin
        rem_r <= rem_next;
        q_r   <= {q_r[QBITS-2:0], q_bit};
        cnt   <= cnt - 5'd1;
      end
      // Stage p1: normalize quotient into fraction plus guard/round/sticky
      S_NORMALIZE: begin
        if (q_r[QBITS-1]) begin
          frac_p1 <= q_r[QBITS-2:3];
          g_p1    <= q_r[2];
          r_p1    <= q_r[1];
          s_p1    <= q_r[0] | (rem_r != 25'd0);
        end else begin
          frac_p1 <= q_r[QBITS-3:2];
          g_p1    <= q_r[1];
          r_p1    <= q_r[0];
          s_p1    <= (rem_r != 25'd0);
          exp_r   <= exp_r - 10'sd1;
        end
      end
      default: ;
    endcase
  end

  // Stage p2: round and publish the result
  always_ff @(posedge clock) begin
    if (reset) begin
      done      <= 1'b0;
      resultado <= 32'h0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_ROUND) begin
        resultado <= round_pack(sign_r, exp_r, frac_p1, g_p1, r_p1, s_p1);
        div_zero  <= 1'b0;
        done      <= 1'b1;
      end else if (state == S_SPECIAL) begin
        resultado <= spec_res_r;
        div_zero  <= spec_dz_r;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases plus randomized operands
// compared with an exact-quotient round-to-nearest-even reference.
module tb_fp_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] operando_a = 32'h0;
  logic [31:0] operando_b = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] resultado;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  fp_div dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .busy       (busy),
    .done       (done),
    .resultado  (resultado),
    .div_zero   (div_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact quotient scaled to 24 significant bits, then nearest-even on the remainder.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic dz, output int lat);
    int ea, eb, e, k;
    logic s;
    longint unsigned ma, mb, num, qt, rm;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    s   = a[31] ^ b[31];
    dz  = 1'b0;
    lat = 1;
`ifdef FP_DIV_SPECIAL_EN
    if (ea == 255 || eb == 255) begin
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) || (ea == 255 && eb == 255))
        res = 32'h7FC00000;
      else if (ea == 255)
        res = {s, 8'hFF, 23'h0};
      else
        res = {s, 31'h0};
      return;
    end
`endif
    if (eb == 0 && ea != 0) begin
      res = {s, 8'hFF, 23'h0};
      dz  = 1'b1;
      return;
    end
    if (ea == 0) begin
      res = {s, 31'h0};
      return;
    end
    lat = 29;
    ma  = 64'h800000 | longint'(a[22:0]);
    mb  = 64'h800000 | longint'(b[22:0]);
    e   = ea - eb + 127;
    if (ma >= mb) k = 23;
    else begin
      k = 24;
      e = e - 1;
    end
    num = ma << k;
    qt  = num / mb;
    rm  = num % mb;
    if (2 * rm > mb || (2 * rm == mb && qt[0])) qt = qt + 1;
    if (qt == 64'h1000000) begin
      qt = 64'h800000;
      e  = e + 1;
    end
    if (e >= 255)     res = {s, 8'hFF, 23'h0};
    else if (e <= 0)  res = {s, 31'h0};
    else              res = {s, 8'(e), qt[22:0]};
  endfunction

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eres;
    logic        edz;
    int          elat, lat;
    ref_div(a, b, eres, edz, elat);
    @(negedge clock);
    operando_a = a;
    operando_b = b;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    operando_a = $urandom;
    operando_b = $urandom;
    chk({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_res"}, resultado, eres);
    chk({tag, "_dz"}, div_zero, edz);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    @(posedge clock);
    #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [31:0] a, b, eres, eres2;
    logic        edz;
    int          elat, lat, seen;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_res", resultado, 32'h0);
    chk("rst_dz", div_zero, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    do_div("six_by_two", 32'h40C00000, 32'h40000000);
    chk("six_by_two_const", resultado, 32'h40400000);
    do_div("one_third", 32'h3F800000, 32'h40400000);
    chk("one_third_const", resultado, 32'h3EAAAAAB);
    do_div("neg_quarter", 32'hBF800000, 32'h40800000);
    chk("neg_quarter_const", resultado, 32'hBE800000);
    do_div("overflow", 32'h7F000000, 32'h3E800000);
    chk("overflow_const", resultado, 32'h7F800000);
    do_div("zero_num", 32'h00000000, 32'h40A00000);
    chk("zero_num_const", resultado, 32'h00000000);
    do_div("underflow", 32'h00800000, 32'h7F000000);
    do_div("div_by_zero", 32'h3F800000, 32'h00000000);
    chk("div_by_zero_const", resultado, 32'h7F800000);
    chk("div_by_zero_flag", div_zero, 1'b1);
`ifdef FP_DIV_SPECIAL_EN
    do_div("nan_in", 32'h7FC00001, 32'h3F800000);
    chk("nan_in_const", resultado, 32'h7FC00000);
    do_div("inf_inf", 32'h7F800000, 32'hFF800000);
    do_div("inf_zero", 32'h7F800000, 32'h00000000);
    do_div("x_inf", 32'h40000000, 32'h7F800000);
`endif

    // start held high through a divide, then accepted again in the done cycle
    ref_div(32'h40C00000, 32'h40000000, eres, edz, elat);
    ref_div(32'h3F800000, 32'h40400000, eres2, edz, elat);
    @(negedge clock);
    operando_a = 32'h40C00000;
    operando_b = 32'h40000000;
    start      = 1'b1;
    @(posedge clock);
    #1;
    operando_a = 32'h3F800000;
    operando_b = 32'h40400000;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("held_lat", lat, 29);
    chk("held_res", resultado, eres);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("b2b_lat", lat, 29);
    chk("b2b_res", resultado, eres2);
    @(posedge clock);
    #1;

    // reset in the middle of a divide; previous result has div_zero set
    do_div("pre_reset", 32'h40000000, 32'h00000000);
    @(negedge clock);
    operando_a = 32'h3F800000;
    operando_b = 32'h40400000;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_res", resultado, 32'h0);
    chk("midrst_dz", div_zero, 1'b0);
    chk("midrst_done", done, 1'b0);
    seen = 0;
    repeat (35) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_res_hold", resultado, 32'h0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 9) == 0) a[30:23] = 8'd0;
      if ($urandom_range(0, 9) == 0) b[30:23] = 8'd0;
      if ($urandom_range(0, 1) == 0) b[30:23] = a[30:23] + 8'($urandom_range(0, 20)) - 8'd10;
      if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0];
      do_div($sformatf("rnd%0d", i), a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
